seq_serializer: RTL and testbench

- Transmit end of the 7-bit serial sequence link: accepts parallel 7-bit words over a valid/ready handshake and shifts them out MSB-first (bit 6 down to bit 0), one bit per clk.
- Produces the serial stream and bit index consumed by the sequence-detector side, plus frame markers and a sent-frame counter.
- A one-word holding buffer allows back-to-back frames with no idle bit between words.

---
 rtl/seq_link_pkg.sv | 14 +
 rtl/seq_hold_buf.sv | 34 +++
 rtl/seq_serializer.sv | 121 ++++++++++++
 tb/tb_seq_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_link_pkg.sv
// Shared constants for the 7-bit serial sequence link (serializer and detector sides).
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: frame width, bit-index width, FSM state encodings.
package seq_link_pkg;

   localparam int WORD_W = 7;   // bits per frame
   localparam int IDX_W  = 3;   // width of the bit index carried next to the serial bit

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

endpackage

// File: rtl/seq_hold_buf.sv
// One-entry holding buffer with a valid/ready write side and an explicit pop.
// Latency: a word written at edge E is visible on out_data/full from cycle E+1.
// Backpressure: in_ready drops while the entry is full or reset is high; never overwrites.
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready write side;
//        out_data/full read side; pop frees the entry at the next edge.
module seq_hold_buf #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         full,
   input  logic         pop
);

   assign in_ready = !reset && !full;

   // A write can only happen while empty, so write and pop never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         full     <= 1'b0;
         out_data <= '0;
      end else if (in_valid && in_ready) begin
         full     <= 1'b1;
         out_data <= in_data;
      end else if (pop) begin
         full     <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_serializer.sv
// Transmit end of the serial sequence link: parallel words in, MSB-first bit stream out.
// Latency: word accepted at edge E puts its MSB on bit_out in cycle E+1; frames run back to back.
// Backpressure: one word may wait in the holding buffer; in_ready drops while it is full or in reset.
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready word input;
//        bit_out/bit_valid/bit_idx serial stream; frame_start/frame_end markers;
//        busy (frame, gap or held word pending); frames_sent completed-frame counter.
module seq_serializer
   import seq_link_pkg::*;
#(
   parameter int WORD_W     = seq_link_pkg::WORD_W,
   parameter int GAP_CYCLES = 0,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bit_out,
   output logic              bit_valid,
   output logic [IDX_W-1:0]  bit_idx,
   output logic              frame_start,
   output logic              frame_end,
   output logic              busy,
   output logic [CNT_W-1:0]  frames_sent
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);

   logic [1:0]        state;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] hold_data;
   logic [IDX_W-1:0]  idx;
   logic [GW-1:0]     gap_cnt;
   logic              hold_full;
   logic              accept;
   logic              slot_end;
   logic              direct;
   logic              pop;

   // slot_end marks the edge where the next frame may begin: the last bit of a
   // frame when frames are contiguous, or the last gap cycle otherwise.
   assign slot_end = ((state == SHIFT) && (idx == '0) && (GAP_CYCLES == 0)) ||
                     ((state == GAP) && (gap_cnt == '0));
   // Words arriving when the shifter is free bypass the holding buffer.
   assign direct   = (state == IDLE) || slot_end;
   assign accept   = in_valid && in_ready;
   assign pop      = slot_end && hold_full;

   seq_hold_buf #(.W(WORD_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid && !direct),
      .in_ready (in_ready),
      .out_data (hold_data),
      .full     (hold_full),
      .pop      (pop)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         idx         <= IDX_TOP;
         gap_cnt     <= '0;
         frames_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= in_data;
                  idx   <= IDX_TOP;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               shreg <= shreg << 1;
               idx   <= idx - 1'b1;
               if (idx == '0) begin
                  frames_sent <= frames_sent + CNT_W'(1);
                  if (GAP_CYCLES > 0) begin
                     state   <= GAP;
                     gap_cnt <= GW'(GAP_CYCLES - 1);
                     idx     <= IDX_TOP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt != '0)
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase

         // Start of the next frame; overrides the per-state updates above.
         // The held word is older than anything on in_data, so it goes first.
         if (slot_end) begin
            idx <= IDX_TOP;
            if (hold_full) begin
               shreg <= hold_data;
               state <= SHIFT;
            end else if (accept) begin
               shreg <= in_data;
               state <= SHIFT;
            end else begin
               state <= IDLE;
            end
         end
      end
   end

   assign bit_valid   = (state == SHIFT);
   assign bit_out     = bit_valid && shreg[WORD_W-1];
   assign bit_idx     = idx;
   assign frame_start = bit_valid && (idx == IDX_TOP);
   assign frame_end   = bit_valid && (idx == '0);
   assign busy        = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: a contiguous instance and a GAP_CYCLES=2 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] in_data0, in_data2;
   logic       in_valid0, in_valid2;
   logic       in_ready0, bit_out0, bit_valid0, frame_start0, frame_end0, busy0;
   logic       in_ready2, bit_out2, bit_valid2, frame_start2, frame_end2, busy2;
   logic [2:0] bit_idx0, bit_idx2;
   logic [7:0] frames_sent0, frames_sent2;

   always #5 clk = ~clk;

   seq_serializer u0 (
      .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .bit_out(bit_out0), .bit_valid(bit_valid0), .bit_idx(bit_idx0),
      .frame_start(frame_start0), .frame_end(frame_end0), .busy(busy0), .frames_sent(frames_sent0)
   );

   seq_serializer #(.GAP_CYCLES(2)) u2 (
      .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
      .bit_out(bit_out2), .bit_valid(bit_valid2), .bit_idx(bit_idx2),
      .frame_start(frame_start2), .frame_end(frame_end2), .busy(busy2), .frames_sent(frames_sent2)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reassemble transmitted frames from the serial stream.
   logic [6:0] acc0 = '0, acc2 = '0;
   logic [6:0] rx0[$];
   logic [6:0] rx2[$];
   logic [6:0] exp0[$];

   always @(negedge clk) begin
      if (bit_valid0) begin
         acc0 = {acc0[5:0], bit_out0};
         if (frame_end0) rx0.push_back(acc0);
      end
      if (bit_valid2) begin
         acc2 = {acc2[5:0], bit_out2};
         if (frame_end2) rx2.push_back(acc2);
      end
   end

   task automatic cmp_rx0(input string tag);
      chk({tag, "_nframes"}, rx0.size(), exp0.size());
      for (int i = 0; i < exp0.size() && i < rx0.size(); i++)
         chk({tag, "_word"}, rx0[i], exp0[i]);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_bit_out"},   bit_out0,     0);
      chk({tag, "_bit_valid"}, bit_valid0,   0);
      chk({tag, "_bit_idx"},   bit_idx0,     6);
      chk({tag, "_fstart"},    frame_start0, 0);
      chk({tag, "_fend"},      frame_end0,   0);
      chk({tag, "_busy"},      busy0,        0);
      chk({tag, "_frames"},    frames_sent0, 0);
      chk({tag, "_ready"},     in_ready0,    0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      logic [6:0] w;
      logic [6:0] wa, wb;
      logic [6:0] tab[4];
      int nacc, nv, k;

      reset = 1'b1;
      in_valid0 = 1'b0; in_data0 = '0;
      in_valid2 = 1'b0; in_data2 = '0;
      repeat (2) step();

      // Reset state
      chk_reset_state("rst");
      reset = 1'b0;
      #1;
      chk("rst_ready_after", in_ready0, 1);

      // GAP_CYCLES=2: two queued words, exactly two idle cycles between frames
      wa = 7'b1010101;
      wb = 7'b0110011;
      for (int s = 0; s < 20; s++) begin
         chk("gap_vld",  bit_valid2,   ((s >= 1 && s <= 7) || (s >= 10 && s <= 16)) ? 1 : 0);
         chk("gap_fs",   frame_start2, (s == 1 || s == 10) ? 1 : 0);
         chk("gap_idle_bit", bit_out2 & !bit_valid2, 0);
         if (s == 9 || s == 10) chk("gap_ready", in_ready2, (s == 10) ? 1 : 0);
         in_valid2 = (s < 2);
         in_data2  = (s == 0) ? wa : wb;
         step();
      end
      in_valid2 = 1'b0;
      chk("gap_frames", frames_sent2, 2);
      chk("gap_busy",   busy2, 0);
      chk("gap_nrx",    rx2.size(), 2);
      if (rx2.size() == 2) begin
         chk("gap_w0", rx2[0], wa);
         chk("gap_w1", rx2[1], wb);
      end

      // Single frame 1001001
      w = 7'b1001001;
      in_data0 = w; in_valid0 = 1'b1;
      chk("t1_ready", in_ready0, 1);
      step();
      in_valid0 = 1'b0;
      exp0.push_back(w);
      for (int i = 0; i < 7; i++) begin
         chk("t1_vld",  bit_valid0,   1);
         chk("t1_bit",  bit_out0,     w[6-i]);
         chk("t1_idx",  bit_idx0,     6 - i);
         chk("t1_fs",   frame_start0, (i == 0) ? 1 : 0);
         chk("t1_fe",   frame_end0,   (i == 6) ? 1 : 0);
         step();
      end
      chk("t1_idle_vld", bit_valid0, 0);
      chk("t1_frames",   frames_sent0, 1);
      chk("t1_busy",     busy0, 0);
      chk("t1_idle_idx", bit_idx0, 6);

      // Back-to-back 1111111 then 0000000 with no bubble
      in_data0 = 7'b1111111; in_valid0 = 1'b1;
      step();
      exp0.push_back(7'b1111111);
      for (int i = 0; i < 16; i++) begin
         chk("b2b_vld",   bit_valid0,   (i < 14) ? 1 : 0);
         chk("b2b_fs",    frame_start0, (i == 0 || i == 7) ? 1 : 0);
         chk("b2b_ready", in_ready0,    (i == 0 || i >= 7) ? 1 : 0);
         chk("b2b_bit",   bit_out0,     (i < 7) ? 1 : 0);
         in_valid0 = (i == 0);
         in_data0  = 7'b0000000;
         if (i == 0) exp0.push_back(7'b0000000);
         step();
      end
      in_valid0 = 1'b0;
      chk("b2b_frames", frames_sent0, 3);
      cmp_rx0("b2b");

      // Stall: in_valid held 10 cycles while the hold fills
      tab[0] = 7'h2A; tab[1] = 7'h15; tab[2] = 7'h4C; tab[3] = 7'h33;
      nacc = 0;
      for (int s = 0; s < 10; s++) begin
         in_valid0 = (nacc < 4);
         in_data0  = tab[nacc % 4];
         if (in_valid0 && in_ready0) begin
            exp0.push_back(tab[nacc % 4]);
            nacc++;
         end
         step();
      end
      in_valid0 = 1'b0;
      chk("stall_accepts", nacc, 3);
      k = 0;
      while (busy0 && k < 40) begin
         step();
         k++;
      end
      chk("stall_drain", busy0, 0);
      chk("stall_frames", frames_sent0, 6);
      cmp_rx0("stall");

      // Reset mid-frame with a word held
      in_data0 = 7'b1100110; in_valid0 = 1'b1;
      step();
      exp0.push_back(7'b1100110);   // pushed only to keep the count; removed below
      void'(exp0.pop_back());
      in_data0 = 7'b0011001;
      step();
      in_valid0 = 1'b0;
      chk("ra_held", in_ready0, 0);
      step();
      step();
      chk("ra_idx3", bit_idx0, 3);
      chk("ra_busy", busy0, 1);
      reset = 1'b1;
      step();
      chk_reset_state("ra");
      reset = 1'b0;
      #1;
      chk("ra_ready_after", in_ready0, 1);
      nv = 0;
      for (int s = 0; s < 20; s++) begin
         if (bit_valid0) nv++;
         step();
      end
      chk("ra_no_tx", nv, 0);
      chk("ra_frames", frames_sent0, 0);
      cmp_rx0("ra");

      // 256 contiguous frames: counter wraps back to 0
      nacc = 0;
      nv = 0;
      k = 0;
      while (k < 3000 && !(nacc == 256 && !busy0)) begin
         in_valid0 = (nacc < 256);
         in_data0  = nacc[6:0];
         if (in_valid0 && in_ready0) begin
            exp0.push_back(nacc[6:0]);
            nacc++;
         end
         if (bit_valid0) nv++;
         step();
         k++;
      end
      in_valid0 = 1'b0;
      chk("wrap_accepts", nacc, 256);
      chk("wrap_busy",    busy0, 0);
      chk("wrap_count",   frames_sent0, 0);
      chk("wrap_bits",    nv, 1792);
      cmp_rx0("wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
